// File: rtl/pd_pluse_timer_if.sv
// -----------------------------------------------------------------------------
// pd_pluse_timer_if
// Bundle of the request/status signals between a sequencer (master) and the
// pulse timer (slave).
//
// Handshake: start is a single-cycle request. The timer accepts it only while
// it is idle (busy low); a start seen while busy is dropped, not queued. The
// sequence ends either with a one-cycle done strobe (busy drops on the
// following edge) or silently on abort or reset. stateover is the external
// acknowledge: it is sampled low only while the timer waits for it.
//
// Signals:
//   start, abort       request / cancel of one pulse sequence
//   mode, branch       path selects, latched with start
//   delay_len          pre-pulse delay (cycles), latched with start
//   pulse_len          pulse window (cycles), latched with start
//   stateover          acknowledge from the sequence state machine, active low
//   i[5:0]             phase flags
//   busy, done, err    status
// -----------------------------------------------------------------------------
interface pd_pluse_timer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             abort;
   logic             mode;
   logic             branch;
   logic [CNT_W-1:0] delay_len;
   logic [CNT_W-1:0] pulse_len;
   logic             stateover;
   logic [5:0]       i;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, abort, mode, branch, delay_len, pulse_len, stateover,
      input  i, busy, done, err
   );

   modport slave (
      input  start, abort, mode, branch, delay_len, pulse_len, stateover,
      output i, busy, done, err
   );
endinterface

// File: rtl/pd_pluse_timer.sv
// -----------------------------------------------------------------------------
// pd_pluse_timer
// Runs one pulse sequence per accepted start: ARM (1 cycle), DELAY (D cycles),
// PULSE (P cycles), WAIT_ACK (until stateover low or timeout), DONE (1 cycle).
// Phase flags in i are levels that accumulate through the sequence and clear
// together at DONE, abort or reset.
//
// Ports:
//   dds          clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          pd_pluse_timer_if.slave (request, lengths, ack, flags, status)
//   dbg_state_o  current FSM state encoding
//
// ACK_TIMEOUT must not exceed 2**CNT_W because the phase counter is reused to
// time the acknowledge wait.
// -----------------------------------------------------------------------------
module pd_pluse_timer #(
   parameter int CNT_W       = 16,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic                    dds,
   input  logic                    rst_n,
   pd_pluse_timer_if.slave         bus,
   output logic [2:0]              dbg_state_o
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARM      = 3'd1,
      DELAY    = 3'd2,
      PULSE    = 3'd3,
      WAIT_ACK = 3'd4,
      DONE     = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] d_len_q, d_len_d;
   logic [CNT_W-1:0] p_len_q, p_len_d;
   logic             branch_q, branch_d;
   logic [5:0]       i_q, i_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_inc;

   // Saturating increment: the counter never wraps, so lengths up to
   // 2**CNT_W-1 still terminate (the compare value is at most all-ones minus 1).
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ONE;

   always_ff @(posedge dds) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         d_len_q  <= '0;
         p_len_q  <= '0;
         branch_q <= 1'b0;
         i_q      <= 6'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         d_len_q  <= d_len_d;
         p_len_q  <= p_len_d;
         branch_q <= branch_d;
         i_q      <= i_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      d_len_d  = d_len_q;
      p_len_d  = p_len_q;
      branch_d = branch_q;
      i_d      = i_q;
      done_d   = 1'b0;
      err_d    = err_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = ARM;
               cnt_d    = '0;
               d_len_d  = (bus.delay_len == '0) ? ONE : bus.delay_len;
               p_len_d  = (bus.pulse_len == '0) ? ONE : bus.pulse_len;
               branch_d = bus.branch;
               err_d    = 1'b0;
               i_d      = {bus.mode, 3'b000, bus.branch, 1'b1};
            end
         end
         ARM: begin
            state_d = DELAY;
            cnt_d   = '0;
         end
         // The counter holds elapsed cycles minus one, so comparing against
         // length-1 makes the phase last exactly length cycles.
         DELAY: begin
            if (cnt_q == d_len_q - ONE) begin
               state_d = PULSE;
               cnt_d   = '0;
               i_d[2]  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         PULSE: begin
            if (cnt_q == p_len_q - ONE) begin
               state_d = WAIT_ACK;
               cnt_d   = '0;
               if (branch_q) i_d[4] = 1'b1;
               else          i_d[3] = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         // An acknowledge on the final timeout cycle still counts as on time.
         WAIT_ACK: begin
            if (!bus.stateover || cnt_q == ACK_LAST) begin
               state_d = DONE;
               cnt_d   = '0;
               i_d     = 6'b0;
               done_d  = 1'b1;
               err_d   = bus.stateover;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            i_d     = 6'b0;
         end
      endcase

      // Abort overrides everything except an idle start.
      if (bus.abort && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
         i_d     = 6'b0;
         done_d  = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   assign bus.i       = i_q;
   assign bus.done    = done_q;
   assign bus.busy    = busy_q;
   assign bus.err     = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pd_pluse_timer.sv
module tb_pd_pluse_timer;

   localparam int CNT_W  = 4;
   localparam int ACK_TO = 8;

   // ---------------- clock / reset ----------------
   logic       dds   = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] dbg_state;

   always #5 dds = ~dds;

   pd_pluse_timer_if #(.CNT_W(CNT_W)) bus ();

   pd_pluse_timer #(.CNT_W(CNT_W), .ACK_TIMEOUT(ACK_TO)) dut (
      .dds         (dds),
      .rst_n       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // ---------------- reference model (timeline arithmetic) ----------------
   // A sequence is described by its start edge t0 and effective lengths.
   // Relative to t0: i[2] rises at D+1, pulse ends at D+1+P, the ack window
   // spans the ACK_TO edges after that, done is shown for one edge.
   int cyc = 0;
   bit m_active = 0;
   int m_t0, m_d, m_p, m_done_n;
   bit m_mode, m_branch;
   bit m_err = 0;

   int obs_i2, obs_i34, obs_done;
   bit seen_i3;

   task automatic model_edge();
      int k, kp;
      if (!rst_n) begin
         m_active = 0;
         m_err    = 0;
      end else if (m_active) begin
         k  = cyc - m_t0;
         kp = m_d + 1 + m_p;
         if (m_done_n >= 0 && cyc == m_done_n + 1) m_active = 0;
         else if (bus.abort) m_active = 0;
         else if (m_done_n < 0 && k > kp) begin
            if (!bus.stateover) m_done_n = cyc;
            else if (k == kp + ACK_TO) begin
               m_done_n = cyc;
               m_err    = 1;
            end
         end
      end else if (bus.start) begin
         m_active = 1;
         m_t0     = cyc;
         m_mode   = bus.mode;
         m_branch = bus.branch;
         m_d      = (bus.delay_len == 0) ? 1 : int'(bus.delay_len);
         m_p      = (bus.pulse_len == 0) ? 1 : int'(bus.pulse_len);
         m_done_n = -1;
         m_err    = 0;
         obs_i2   = -1;
         obs_i34  = -1;
         obs_done = -1;
         seen_i3  = 0;
      end
   endtask

   task automatic compare_outputs();
      logic [5:0] ei;
      logic       ed, eb;
      int k, kp;
      ei = 6'b0; ed = 1'b0; eb = 1'b0;
      if (m_active) begin
         k  = cyc - m_t0;
         kp = m_d + 1 + m_p;
         eb = 1'b1;
         if (cyc == m_done_n) ed = 1'b1;
         else begin
            ei[0] = 1'b1;
            ei[1] = m_branch;
            ei[5] = m_mode;
            ei[2] = (k >= m_d + 1);
            ei[3] = (k >= kp) && !m_branch;
            ei[4] = (k >= kp) && m_branch;
         end
      end
      check("i",    32'(bus.i),    32'(ei));
      check("done", 32'(bus.done), 32'(ed));
      check("busy", 32'(bus.busy), 32'(eb));
      check("err",  32'(bus.err),  32'(m_err));
      if (bus.i[2] && obs_i2 < 0) obs_i2 = cyc - m_t0;
      if ((bus.i[3] || bus.i[4]) && obs_i34 < 0) obs_i34 = cyc - m_t0;
      if (bus.done && obs_done < 0) obs_done = cyc - m_t0;
      if (bus.i[3]) seen_i3 = 1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge dds);
      cyc++;
      model_edge();
      #1;
      compare_outputs();
   endtask

   task automatic idle_inputs();
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.stateover = 1'b1;
   endtask

   task automatic issue(input bit md, input bit br, input int dl, input int pl);
      bus.mode      = md;
      bus.branch    = br;
      bus.delay_len = CNT_W'(dl);
      bus.pulse_len = CNT_W'(pl);
      bus.start     = 1'b1;
      step();
      bus.start     = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_inputs();
      bus.mode = 0; bus.branch = 0; bus.delay_len = '0; bus.pulse_len = '0;
      rst_n = 1'b0;
      bus.start = 1'b1;             // reset must override start
      repeat (2) step();
      check("rst_i",    32'(bus.i),    32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      bus.start = 1'b0;
      rst_n = 1'b1;
      step();

      // Basic sequence with acknowledge two cycles after i[3].
      issue(0, 0, 5, 3);
      repeat (11) step();
      bus.stateover = 1'b0; step(); bus.stateover = 1'b1;
      repeat (3) step();
      check("seq_i2_at",   32'(obs_i2),   32'd6);
      check("seq_i3_at",   32'(obs_i34),  32'd9);
      check("seq_done_at", 32'(obs_done), 32'd12);

      // Zero lengths clamp to one; branch 1 sets i[4] only.
      issue(1, 1, 0, 0);
      check("min_flags", 32'(bus.i), 32'h23);
      repeat (3) step();
      bus.stateover = 1'b0; step(); bus.stateover = 1'b1;
      repeat (2) step();
      check("min_i2_at",   32'(obs_i2),   32'd2);
      check("min_i4_at",   32'(obs_i34),  32'd3);
      check("min_no_i3",   32'(seen_i3),  32'd0);
      check("min_done_at", 32'(obs_done), 32'd4);

      // Acknowledge timeout: err sticky until next start.
      issue(0, 0, 1, 1);
      repeat (14) step();
      check("to_done_at", 32'(obs_done), 32'd11);
      check("to_err_sticky", 32'(bus.err), 32'd1);
      issue(0, 1, 2, 2);
      check("to_err_clear", 32'(bus.err), 32'd0);
      bus.abort = 1'b1; step(); bus.abort = 1'b0;
      step();

      // Abort in PULSE, with an ignored start during the run.
      issue(0, 0, 3, 6);
      repeat (2) step();
      bus.start = 1'b1; step(); bus.start = 1'b0;
      repeat (2) step();
      bus.abort = 1'b1; step(); bus.abort = 1'b0;
      check("abort_i", 32'(bus.i), 32'd0);
      repeat (15) step();
      check("abort_no_done", 32'(obs_done), 32'hffff_ffff);

      // One-cycle reset in DELAY, then a start on the next edge.
      issue(1, 0, 8, 2);
      repeat (3) step();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      issue(0, 0, 2, 2);
      check("rst_restart", 32'(bus.i), 32'd1);
      repeat (5) step();
      bus.stateover = 1'b0; step(); bus.stateover = 1'b1;
      step();
      check("rst_run_done", 32'(obs_done), 32'd6);

      // Maximum lengths: counter must not wrap.
      issue(0, 1, 15, 15);
      repeat (31) step();
      bus.stateover = 1'b0; step(); bus.stateover = 1'b1;
      step();
      check("max_i2_at",   32'(obs_i2),   32'd16);
      check("max_i4_at",   32'(obs_i34),  32'd31);
      check("max_done_at", 32'(obs_done), 32'd32);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst_n         = ($urandom_range(0, 199) != 0);
         bus.start     = ($urandom_range(0, 5) == 0);
         bus.abort     = ($urandom_range(0, 49) == 0);
         bus.stateover = ($urandom_range(0, 3) != 0);
         bus.mode      = 1'($urandom_range(0, 1));
         bus.branch    = 1'($urandom_range(0, 1));
         bus.delay_len = CNT_W'($urandom_range(0, 15));
         bus.pulse_len = CNT_W'($urandom_range(0, 15));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
